// File: rtl/sb_rx_pkg.sv
// Shared types, constants and helpers for the sideband receive control path.
package sb_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PATTERN,
    DATA,
    DELIVER
  } state_t;

  localparam logic [63:0] SB_PATTERN_WORD = 64'hAAAA_AAAA_AAAA_AAAA;

  localparam logic [4:0] OPC_MSG_DATA_A = 5'b11011;
  localparam logic [4:0] OPC_MSG_DATA_B = 5'b11001;

  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned OPC_MSB = 4;
  localparam int unsigned CP_BIT  = 62;
  localparam int unsigned DP_BIT  = 63;

  function automatic logic has_data(input logic [4:0] opcode);
    return (opcode == OPC_MSG_DATA_A) || (opcode == OPC_MSG_DATA_B);
  endfunction

  // DP covers the data word; a no-data message passes an all-zero word so DP must be 0.
  function automatic logic msg_parity_ok(input logic [63:0] hdr, input logic [63:0] data);
    return (hdr[CP_BIT] == ^hdr[CP_BIT-1:0]) && (hdr[DP_BIT] == ^data);
  endfunction

endpackage

// File: rtl/sb_rx_pattern_det.sv
// Counts consecutive SB initialisation pattern words and emits a one-cycle detect pulse.
module sb_rx_pattern_det
  import sb_rx_pkg::*;
#(
  parameter int unsigned PATTERN_WORDS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        active,
  input  logic        valid,
  input  logic [63:0] data,
  output logic        hit,
  output logic        detected
);

  localparam int unsigned CNT_W = $clog2(PATTERN_WORDS + 1);

  logic [CNT_W-1:0] match_cnt;
  logic             is_pattern;

  assign is_pattern = (data == SB_PATTERN_WORD);
  assign hit        = active && valid && is_pattern &&
                      (match_cnt == CNT_W'(PATTERN_WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
      detected  <= 1'b0;
    end else begin
      detected <= hit;
      if (!active || hit || (valid && !is_pattern)) begin
        match_cnt <= '0;
      end else if (valid) begin
        match_cnt <= match_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sb_rx_fsm.sv
// Sideband RX control FSM: pattern search, header/data capture, delivery handshake.
// Build option: SB_RX_PARITY_CHK_EN enables CP/DP checking and o_parity_err.
module sb_rx_fsm
  import sb_rx_pkg::*;
#(
  parameter int unsigned PATTERN_WORDS  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_deser_valid,
  input  logic [63:0] i_deser_data,
  input  logic        i_pattern_detect_en,
  input  logic        i_msg_ready,
  output logic        o_pattern_detected,
  output logic        o_header_decoder_enable,
  output logic        o_data_decoder_enable,
  output logic        o_msg_valid,
  output logic [63:0] o_msg_header,
  output logic [63:0] o_msg_data,
  output logic        o_msg_has_data,
  output logic        o_rx_sb_rsp_delivered,
  output logic        o_parity_err,
  output logic        o_frame_err,
  output logic        o_overflow,
  output logic        o_busy
);

  state_t state, state_d;

  logic [63:0]     hdr_q, hdr_d;
  logic [63:0]     data_q, data_d;
  logic            has_q, has_d;
  logic [TO_W-1:0] to_cnt, to_d;

  logic hdr_en_q, hdr_en_d;
  logic data_en_q, data_en_d;
  logic dlv_q, dlv_d;
  logic perr_q, perr_d;
  logic ferr_q, ferr_d;
  logic ovf_q, ovf_d;

  logic pat_active, pat_hit, pat_pulse;
  logic hdr_par_ok, data_par_ok;

`ifdef SB_RX_PARITY_CHK_EN
  assign hdr_par_ok  = msg_parity_ok(i_deser_data, 64'd0);
  assign data_par_ok = msg_parity_ok(hdr_q, i_deser_data);
`else
  assign hdr_par_ok  = 1'b1;
  assign data_par_ok = 1'b1;
`endif

  assign pat_active = (state == PATTERN) && i_pattern_detect_en;

  sb_rx_pattern_det #(
    .PATTERN_WORDS (PATTERN_WORDS)
  ) u_pattern_det (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .active   (pat_active),
    .valid    (i_deser_valid),
    .data     (i_deser_data),
    .hit      (pat_hit),
    .detected (pat_pulse)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      hdr_q     <= '0;
      data_q    <= '0;
      has_q     <= 1'b0;
      to_cnt    <= '0;
      hdr_en_q  <= 1'b0;
      data_en_q <= 1'b0;
      dlv_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state     <= state_d;
      hdr_q     <= hdr_d;
      data_q    <= data_d;
      has_q     <= has_d;
      to_cnt    <= to_d;
      hdr_en_q  <= hdr_en_d;
      data_en_q <= data_en_d;
      dlv_q     <= dlv_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state;
    hdr_d     = hdr_q;
    data_d    = data_q;
    has_d     = has_q;
    to_d      = to_cnt;
    hdr_en_d  = 1'b0;
    data_en_d = 1'b0;
    dlv_d     = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    ovf_d     = ovf_q;

    case (state)
      IDLE: begin
        if (i_pattern_detect_en) begin
          state_d = PATTERN;
        end else if (i_deser_valid) begin
          hdr_d    = i_deser_data;
          data_d   = '0;
          has_d    = has_data(i_deser_data[OPC_MSB:OPC_LSB]);
          hdr_en_d = 1'b1;
          to_d     = '0;
          if (has_d) begin
            state_d = DATA;
          end else if (hdr_par_ok) begin
            state_d = DELIVER;
          end else begin
            perr_d = 1'b1;
          end
        end
      end

      PATTERN: begin
        if (!i_pattern_detect_en || pat_hit) begin
          state_d = IDLE;
        end
      end

      DATA: begin
        if (i_deser_valid) begin
          data_d    = i_deser_data;
          data_en_d = 1'b1;
          if (data_par_ok) begin
            state_d = DELIVER;
          end else begin
            perr_d  = 1'b1;
            state_d = IDLE;
          end
        end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          ferr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          to_d = to_cnt + 1'b1;
        end
      end

      DELIVER: begin
        // o_msg_valid is high for the whole state, so ready alone completes the handshake.
        if (i_deser_valid) begin
          ovf_d = 1'b1;
        end
        if (i_msg_ready) begin
          dlv_d   = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign o_pattern_detected      = pat_pulse;
  assign o_header_decoder_enable = hdr_en_q;
  assign o_data_decoder_enable   = data_en_q;
  assign o_msg_valid             = (state == DELIVER);
  assign o_msg_header            = hdr_q;
  assign o_msg_data              = data_q;
  assign o_msg_has_data          = has_q;
  assign o_rx_sb_rsp_delivered   = dlv_q;
  assign o_parity_err            = perr_q;
  assign o_frame_err             = ferr_q;
  assign o_overflow              = ovf_q;
  assign o_busy                  = (state != IDLE);

endmodule

// File: tb/tb_sb_rx_fsm.sv
// Directed bench for sb_rx_fsm: per-cycle expectation tables built from the message timing rules.
module tb_sb_rx_fsm;

  localparam int N   = 2048;
  localparam int PW  = 2;
  localparam int TMO = 255;
  localparam logic [63:0] PAT  = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] IDLE_BUS = 64'hFFFF_FFFF_FFFF_FFFF;

  localparam int F_PD = 0, F_HE = 1, F_DE = 2, F_MV = 3, F_DL = 4,
                 F_PE = 5, F_FE = 6, F_OV = 7, F_BZ = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        deser_valid = 1'b0;
  logic [63:0] deser_data = '0;
  logic        pattern_en = 1'b0;
  logic        msg_ready = 1'b0;

  logic        pattern_detected, hdr_en, data_en, msg_valid, msg_has_data;
  logic [63:0] msg_header, msg_data;
  logic        delivered, parity_err, frame_err, overflow, busy;

  logic [8:0]  exp_f   [N];
  logic [63:0] exp_hdr [N];
  logic [63:0] exp_dat [N];
  logic        exp_has [N];
  logic [8:0]  act_f;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  bit run = 1'b0;

  sb_rx_fsm #(
    .PATTERN_WORDS  (PW),
    .TIMEOUT_CYCLES (TMO),
    .TO_W           (8)
  ) dut (
    .i_clk                   (clk),
    .i_rst_n                 (rst_n),
    .i_deser_valid           (deser_valid),
    .i_deser_data            (deser_data),
    .i_pattern_detect_en     (pattern_en),
    .i_msg_ready             (msg_ready),
    .o_pattern_detected      (pattern_detected),
    .o_header_decoder_enable (hdr_en),
    .o_data_decoder_enable   (data_en),
    .o_msg_valid             (msg_valid),
    .o_msg_header            (msg_header),
    .o_msg_data              (msg_data),
    .o_msg_has_data          (msg_has_data),
    .o_rx_sb_rsp_delivered   (delivered),
    .o_parity_err            (parity_err),
    .o_frame_err             (frame_err),
    .o_overflow              (overflow),
    .o_busy                  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string fname(input int i);
    case (i)
      F_PD:    return "pattern_detected";
      F_HE:    return "header_decoder_enable";
      F_DE:    return "data_decoder_enable";
      F_MV:    return "msg_valid";
      F_DL:    return "rsp_delivered";
      F_PE:    return "parity_err";
      F_FE:    return "frame_err";
      F_OV:    return "overflow";
      default: return "busy";
    endcase
  endfunction

  // ---- specification model ----
  function automatic logic m_has(input logic [4:0] opc);
    return (opc == 5'b11011) || (opc == 5'b11001);
  endfunction

  function automatic logic [63:0] mk_hdr(input logic [61:0] body, input logic [63:0] data);
    logic [63:0] h;
    h[61:0] = body;
    h[62]   = ^body;
    h[63]   = m_has(body[4:0]) ? ^data : 1'b0;
    return h;
  endfunction

  function automatic logic m_perr(input logic [63:0] hdr, input logic [63:0] data);
`ifdef SB_RX_PARITY_CHK_EN
    logic dp;
    dp = m_has(hdr[4:0]) ? ^data : 1'b0;
    return (hdr[62] != ^hdr[61:0]) || (hdr[63] != dp);
`else
    return 1'b0;
`endif
  endfunction

  task automatic setf(input int f, input int a, input int b);
    for (int c = a; c <= b; c++) if (c < N) exp_f[c][f] = 1'b1;
  endtask

  task automatic set1(input int f, input int c);
    if (c < N) exp_f[c][f] = 1'b1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, expv);
    end
  endtask

  // Header at cycle t; data gap cycles later; ready raised hold cycles after valid rises.
  task automatic run_msg(input logic [63:0] hdr, input logic [63:0] data,
                         input int gap, input int hold);
    int t, d, v, h;
    logic has, pe;
    has = m_has(hdr[4:0]);
    pe  = m_perr(hdr, data);
    t   = cyc;
    d   = t + gap;
    h   = 0;
    set1(F_HE, t + 1);
    if (has) begin
      set1(F_DE, d + 1);
      v = d + 1;
    end else begin
      v = t + 1;
    end
    if (pe) begin
      set1(F_PE, v);
      setf(F_BZ, t + 1, v - 1);
    end else begin
      h = v + hold;
      setf(F_MV, v, h);
      setf(F_BZ, t + 1, h);
      set1(F_DL, h + 1);
      for (int c = v; c <= h; c++) begin
        exp_hdr[c] = hdr;
        exp_dat[c] = has ? data : 64'd0;
        exp_has[c] = has;
      end
    end
    deser_valid = 1'b1;
    deser_data  = hdr;
    tick(1);
    deser_valid = 1'b0;
    deser_data  = IDLE_BUS;
    if (has) begin
      tick(gap - 1);
      deser_valid = 1'b1;
      deser_data  = data;
      tick(1);
      deser_valid = 1'b0;
      deser_data  = IDLE_BUS;
    end
    if (!pe) begin
      tick(h - cyc);
      msg_ready = 1'b1;
      tick(1);
      msg_ready = 1'b0;
    end
  endtask

  task automatic run_pat(input logic [63:0] words[$]);
    int c0, streak, hit;
    c0 = cyc;
    streak = 0;
    hit = -1;
    for (int i = 0; i < words.size(); i++) begin
      streak = (words[i] == PAT) ? streak + 1 : 0;
      if (streak == PW && hit < 0) hit = c0 + 1 + i;
    end
    if (hit >= 0) begin
      set1(F_PD, hit + 1);
      setf(F_BZ, c0 + 1, hit);
    end else begin
      setf(F_BZ, c0 + 1, c0 + 1 + words.size());
    end
    // a header-like word presented together with the enable must be ignored
    pattern_en  = 1'b1;
    deser_valid = 1'b1;
    deser_data  = 64'h4000_0000_0000_0112;
    tick(1);
    for (int i = 0; i < words.size(); i++) begin
      if (hit >= 0 && cyc > hit) break;
      deser_valid = 1'b1;
      deser_data  = words[i];
      tick(1);
    end
    deser_valid = 1'b0;
    deser_data  = IDLE_BUS;
    pattern_en  = 1'b0;
    tick(2);
  endtask

  always @(negedge clk) begin
    if (run && cyc < N) begin
      act_f = {busy, overflow, frame_err, parity_err, delivered,
               msg_valid, data_en, hdr_en, pattern_detected};
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (act_f[i] !== exp_f[cyc][i]) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%b exp=%b", fname(i), cyc, act_f[i], exp_f[cyc][i]);
        end
      end
      if (exp_f[cyc][F_MV]) begin
        checks += 3;
        if (msg_header !== exp_hdr[cyc]) begin
          errors++;
          $display("FAIL msg_header cyc=%0d got=%h exp=%h", cyc, msg_header, exp_hdr[cyc]);
        end
        if (msg_data !== exp_dat[cyc]) begin
          errors++;
          $display("FAIL msg_data cyc=%0d got=%h exp=%h", cyc, msg_data, exp_dat[cyc]);
        end
        if (msg_has_data !== exp_has[cyc]) begin
          errors++;
          $display("FAIL msg_has_data cyc=%0d got=%b exp=%b", cyc, msg_has_data, exp_has[cyc]);
        end
      end
    end
  end

  initial begin
    logic [63:0] q[$];
    logic [63:0] h_nd, h_d1, h_d2;
    int t;

    for (int i = 0; i < N; i++) begin
      exp_f[i]   = '0;
      exp_hdr[i] = '0;
      exp_dat[i] = '0;
      exp_has[i] = 1'b0;
    end
    run = 1'b1;

    h_nd = mk_hdr(62'h112, 64'd0);
    h_d1 = mk_hdr(62'h1B, 64'h0123_4567_89AB_CDEF);
    h_d2 = mk_hdr(62'h19, 64'h1);
    chk64("model_hdr_nodata", h_nd, 64'h4000_0000_0000_0112);
    chk64("model_hdr_data",   h_d1, 64'h0000_0000_0000_001B);
    chk64("model_hdr_dp",     h_d2, 64'hC000_0000_0000_0019);

    tick(3);
    rst_n = 1'b1;
    tick(2);

    // pattern detection
    q = '{PAT, PAT};             run_pat(q);
    q = '{PAT, 64'h1, PAT, PAT}; run_pat(q);
    q = '{PAT};                  run_pat(q);
    q = '{PAT, PAT};             run_pat(q);

    // messages: no-data with immediate ready, data after 3 cycles, held ready, back-to-back
    run_msg(h_nd, 64'd0, 0, 0);
    tick(2);
    run_msg(h_d1, 64'h0123_4567_89AB_CDEF, 3, 0);
    tick(2);
    run_msg(h_d2, 64'h1, 1, 3);
    run_msg(h_nd, 64'd0, 0, 1);
    tick(2);

    // data arriving on the last cycle before timeout is still accepted
    run_msg(h_d1, 64'h0123_4567_89AB_CDEF, TMO, 0);
    tick(2);

    // timeout
    t = cyc;
    set1(F_HE, t + 1);
    setf(F_BZ, t + 1, t + TMO);
    set1(F_FE, t + 1 + TMO);
    deser_valid = 1'b1;
    deser_data  = mk_hdr(62'h1B, 64'd0);
    tick(1);
    deser_valid = 1'b0;
    deser_data  = IDLE_BUS;
    tick(TMO + 3);

    // parity: bad CP on a no-data header, bad DP on a data message
    run_msg(64'h0000_0000_0000_0112, 64'd0, 0, 0);
    tick(2);
    run_msg(64'h8000_0000_0000_001B, 64'h0123_4567_89AB_CDEF, 2, 0);
    tick(2);

    // overflow while delivery is stalled, then reset in DELIVER
    t = cyc;
    set1(F_HE, t + 1);
    setf(F_MV, t + 1, t + 4);
    setf(F_BZ, t + 1, t + 4);
    setf(F_OV, t + 3, t + 4);
    for (int c = t + 1; c <= t + 4; c++) begin
      exp_hdr[c] = h_nd;
      exp_dat[c] = 64'd0;
      exp_has[c] = 1'b0;
    end
    deser_valid = 1'b1;
    deser_data  = h_nd;
    tick(1);
    deser_valid = 1'b0;
    tick(1);
    deser_valid = 1'b1;
    deser_data  = h_d1;
    tick(1);
    deser_valid = 1'b0;
    deser_data  = IDLE_BUS;
    tick(1);
    chk64("stalled_header", msg_header, 64'h4000_0000_0000_0112);
    chk64("stalled_data", msg_data, 64'd0);
    chk64("stalled_overflow", {63'd0, overflow}, 64'd1);
    tick(1);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);

    // reset while waiting for data: no frame error afterwards
    t = cyc;
    set1(F_HE, t + 1);
    setf(F_BZ, t + 1, t + 3);
    deser_valid = 1'b1;
    deser_data  = h_d1;
    tick(1);
    deser_valid = 1'b0;
    deser_data  = IDLE_BUS;
    tick(3);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(8);

    // a fresh message after reset delivers normally
    run_msg(h_d2, 64'h1, 2, 1);
    tick(4);

    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
